store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised store unit between the MEM stage and the data-SRAM-like bus. Accepts SW/SH/SB requests, builds little-endian byte-lane replicated write data and byte strobes, optionally traps misaligned addresses, and queues stores in a DEPTH-entry FIFO. The FIFO drains over a req/addr_ok/data_ok bus with a bounded number of outstanding writes; `drained` tells the pipeline when all stores are globally done.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- MAX_OUT, 2, max writes accepted by the bus (addr_ok) but not yet acknowledged (data_ok); at least 1
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- st_valid  in  1  store request this cycle
- st_op  in  2  01 SW, 10 SH, 11 SB, 00 no store; 00 is ignored even when st_valid=1
- st_addr  in  32  byte address
- st_data  in  32  raw rt value
- flush  in  1  suppresses enqueue of the current request only
- st_ready  out  1  FIFO can accept an entry
- st_ades  out  1  misaligned store flag, combinational
- badvaddr  out  32  st_addr when st_ades=1, else 0
- mem_req  out  1  head entry valid for the bus
- mem_wr  out  1  constant 1
- mem_size  out  2  0 byte, 1 half, 2 word
- mem_addr  out  32  head address
- mem_wstrb  out  4  head byte strobes
- mem_wdata  out  32  head write data
- mem_addr_ok  in  1  bus accepts the head
- mem_data_ok  in  1  one outstanding write completed
- count  out  clog2(DEPTH+1)  occupied entries
- drained  out  1  count==0 and outstanding==0

## Operation
- Data replication:
  - SW: data unchanged.
  - SH: {d[15:0], d[15:0]}.
  - SB: d[7:0] in all four bytes.
- Strobes:
  - SW: 1111.
  - SH: addr[1] ? 1100 : 0011.
  - SB: 0001 << addr[1:0].
- Misaligned: SH with addr[0]=1; SW with addr[1:0]≠0. SB is never misaligned.
- Enqueue when st_valid, st_op≠00, st_ready, !flush, and not trapped. Each entry stores {addr, size, wstrb, wdata}, written at the write pointer.
- st_ready = (count < DEPTH). There is no same-cycle pass-through when full.
- mem_req = (count ≠ 0) && (outstanding < MAX_OUT). mem_* outputs show the head entry.
- Dequeue on mem_req && mem_addr_ok. The outstanding counter increments on dequeue.
- The outstanding counter decrements on mem_data_ok. If dequeue and mem_data_ok fall in the same cycle, it is unchanged.
- A mem_data_ok while outstanding==0 is a protocol error and is ignored; the counter stays at 0.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (resetn=0, async): pointers, count, outstanding and all entries go to 0.
  - Outputs during reset: st_ready=1, drained=1, mem_req=0, mem_* =0 except mem_wr=1, st_ades=0.
  - Reset mid-transaction discards all queued and outstanding stores.
- Enqueue-to-mem_req latency: 1 cycle (entry registered, no bypass).
- mem_req, mem_addr, mem_size, mem_wstrb and mem_wdata depend only on registered state. They hold stable while mem_req=1 and no addr_ok.
- st_ready, count and drained are registered-state functions. st_ades and badvaddr are combinational from the inputs.
- The next head is presented the cycle after mem_addr_ok. Back-to-back dequeues are allowed every cycle while outstanding < MAX_OUT.

## Configuration
- UNALIGNED_TRAP_EN defined:
  - A misaligned request drives st_ades=1 and badvaddr=st_addr.
  - The request is not enqueued.
  - st_ades is raised even if flush=1 or st_ready=0.
- UNALIGNED_TRAP_EN undefined:
  - st_ades and badvaddr are tied to 0.
  - Misaligned addresses are force-aligned before enqueue: SH clears addr[0], SW clears addr[1:0].
  - Strobes are computed from the aligned address.

## Test plan
- SB, addr 0x1003, data 0x123456AB, bus always ready: one cycle later mem_req=1, mem_addr=0x1003, mem_size=0, mem_wstrb=1000, mem_wdata=0xABABABAB. After data_ok, drained=1.
- SH to 0x2002, data 0xFFFF5A5A: mem_wstrb=1100, mem_wdata=0x5A5A5A5A, mem_size=1.
- Fill with DEPTH SW stores while mem_addr_ok=0: st_ready=0 and count=DEPTH. A further st_valid is not enqueued. Releasing addr_ok drains all entries in FIFO order.
- mem_addr_ok=1 and mem_data_ok=0 with MAX_OUT=2: exactly 2 dequeues, then mem_req=0. One data_ok re-enables mem_req the next cycle. A simultaneous addr_ok and data_ok keeps outstanding constant.
- SW to 0x3001:
  - With UNALIGNED_TRAP_EN: st_ades=1, badvaddr=0x3001, count unchanged.
  - Without: entry at 0x3000 with wstrb=1111.
- resetn pulsed low with 3 entries queued and 1 outstanding: count=0, drained=1, mem_req=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: MEM-stage store unit. It builds byte-lane replicated write data
// and strobes for SW/SH/SB, queues stores in a DEPTH-entry FIFO, and drains them
// over a req/addr_ok/data_ok bus with at most MAX_OUT writes in flight.
// Optional feature macro: UNALIGNED_TRAP_EN. When defined, misaligned stores
// raise st_ades and are dropped. When undefined, misaligned stores are
// force-aligned before they are queued.

package store_buffer_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sb_entry_t;
endpackage

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       st_valid,
    input  logic [1:0]                 st_op,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic                       flush,
    output logic                       st_ready,
    output logic                       st_ades,
    output logic [31:0]                badvaddr,
    output logic                       mem_req,
    output logic                       mem_wr,
    output logic [1:0]                 mem_size,
    output logic [31:0]                mem_addr,
    output logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_addr_ok,
    input  logic                       mem_data_ok,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drained
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_SH = 2'b10;
    localparam logic [1:0] OP_SB = 2'b11;

    sb_entry_t         fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [OW-1:0]     out_q;

    sb_entry_t         new_entry;
    sb_entry_t         head;
    logic              trap;
    logic              enq;
    logic              deq;
    logic              dok;

    // Request decode: lane replication, size, strobes and the address to queue
    always_comb begin
        new_entry = '0;
        case (st_op)
            OP_SW: begin
`ifdef UNALIGNED_TRAP_EN
                new_entry.addr = st_addr;
`else
                new_entry.addr = {st_addr[31:2], 2'b00};
`endif
                new_entry.size  = 2'd2;
                new_entry.wstrb = 4'b1111;
                new_entry.wdata = st_data;
            end
            OP_SH: begin
`ifdef UNALIGNED_TRAP_EN
                new_entry.addr = st_addr;
`else
                new_entry.addr = {st_addr[31:1], 1'b0};
`endif
                new_entry.size  = 2'd1;
                new_entry.wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
                new_entry.wdata = {st_data[15:0], st_data[15:0]};
            end
            OP_SB: begin
                new_entry.addr  = st_addr;
                new_entry.size  = 2'd0;
                new_entry.wstrb = 4'b0001 << st_addr[1:0];
                new_entry.wdata = {4{st_data[7:0]}};
            end
            default: new_entry = '0;
        endcase
    end

`ifdef UNALIGNED_TRAP_EN
    logic misaligned;

    // Misalignment detect; raised regardless of flush or FIFO space
    always_comb begin
        misaligned = 1'b0;
        if (st_op == OP_SW) misaligned = (st_addr[1:0] != 2'b00);
        if (st_op == OP_SH) misaligned = st_addr[0];
    end

    assign trap     = st_valid && misaligned;
    assign st_ades  = trap;
    assign badvaddr = trap ? st_addr : 32'h0;
`else
    assign trap     = 1'b0;
    assign st_ades  = 1'b0;
    assign badvaddr = 32'h0;
`endif

    assign st_ready = (count_q < CW'(DEPTH));
    assign enq      = st_valid && (st_op != 2'b00) && st_ready && !flush && !trap;

    assign head      = fifo_q[rd_ptr_q];
    assign mem_req   = (count_q != '0) && (out_q < OW'(MAX_OUT));
    assign mem_wr    = 1'b1;
    assign mem_addr  = head.addr;
    assign mem_size  = head.size;
    assign mem_wstrb = head.wstrb;
    assign mem_wdata = head.wdata;

    assign deq = mem_req && mem_addr_ok;
    // data_ok with nothing in flight is a protocol error and is dropped
    assign dok = mem_data_ok && (out_q != '0);

    assign count   = count_q;
    assign drained = (count_q == '0) && (out_q == '0);

    // Entry storage, written at the write pointer on enqueue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else if (enq) begin
            fifo_q[wr_ptr_q] <= new_entry;
        end
    end

    // Pointers, occupancy and in-flight write counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            case ({deq, dok})
                2'b10:   out_q <= out_q + OW'(1);
                2'b01:   out_q <= out_q - OW'(1);
                default: out_q <= out_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4, MAX_OUT=2); follows whichever
// UNALIGNED_TRAP_EN setting the design is built with.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        flush;
    logic        st_ready;
    logic        st_ades;
    logic [31:0] badvaddr;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [2:0]  count;
    logic        drained;

    int checks   = 0;
    int failures = 0;

    store_buffer #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk(clk), .resetn(resetn), .st_valid(st_valid), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .flush(flush),
        .st_ready(st_ready), .st_ades(st_ades), .badvaddr(badvaddr),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .count(count), .drained(drained)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = d;
    endtask

    task automatic idle;
        st_valid = 1'b0; st_op = 2'b00; st_addr = 32'h0; st_data = 32'h0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #3;
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL rst_st_ready got=%b exp=1", st_ready); end
        checks++; if (drained !== 1'b1) begin failures++; $display("FAIL rst_drained got=%b exp=1", drained); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL rst_mem_wr got=%b exp=1", mem_wr); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb, mem_size} !== 70'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h/%b/%0d exp=0", mem_addr, mem_wdata, mem_wstrb, mem_size); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (st_ades !== 1'b0) begin failures++; $display("FAIL rst_st_ades got=%b exp=0", st_ades); end
        cyc;
        resetn = 1'b1;
        cyc;
    endtask

    task automatic test_sb;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        put(2'b11, 32'h0000_1003, 32'h1234_56AB);
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sb_no_bypass got=%b exp=0", mem_req); end
        cyc;
        idle;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sb_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_1003) begin failures++; $display("FAIL sb_addr got=%h exp=00001003", mem_addr); end
        checks++; if (mem_size !== 2'd0) begin failures++; $display("FAIL sb_size got=%0d exp=0", mem_size); end
        checks++; if (mem_wstrb !== 4'b1000) begin failures++; $display("FAIL sb_wstrb got=%b exp=1000", mem_wstrb); end
        checks++; if (mem_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", mem_wdata); end
        cyc;
        checks++; if ({mem_req, drained, count} !== 5'b00_000) begin failures++; $display("FAIL sb_inflight got=req%b/drn%b/cnt%0d exp=0/0/0", mem_req, drained, count); end
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cyc;
        mem_data_ok = 1'b0;
        checks++; if (drained !== 1'b1) begin failures++; $display("FAIL sb_drained got=%b exp=1", drained); end
    endtask

    task automatic test_sh;
        mem_addr_ok = 1'b0;
        put(2'b10, 32'h0000_2002, 32'hFFFF_5A5A);
        cyc;
        idle;
        cyc;
        checks++; if (mem_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", mem_wstrb); end
        checks++; if (mem_wdata !== 32'h5A5A_5A5A) begin failures++; $display("FAIL sh_wdata got=%h exp=5a5a5a5a", mem_wdata); end
        checks++; if (mem_size !== 2'd1) begin failures++; $display("FAIL sh_size got=%0d exp=1", mem_size); end
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_2002}) begin failures++; $display("FAIL sh_hold got=req%b/%h exp=1/00002002", mem_req, mem_addr); end
        mem_addr_ok = 1'b1;
        cyc;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cyc;
        mem_data_ok = 1'b0;
        checks++; if (drained !== 1'b1) begin failures++; $display("FAIL sh_drained got=%b exp=1", drained); end
    endtask

    task automatic test_ignored;
        mem_addr_ok = 1'b0;
        put(2'b00, 32'h0000_4000, 32'h1111_1111);
        cyc;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL op00_count got=%0d exp=0", count); end
        put(2'b01, 32'h0000_4000, 32'h1111_1111);
        flush = 1'b1;
        cyc;
        flush = 1'b0;
        idle;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(2'b01, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            cyc;
        end
        checks++; if ({st_ready, count} !== 4'b0_100) begin failures++; $display("FAIL fill_full got=rdy%b/cnt%0d exp=0/4", st_ready, count); end
        put(2'b01, 32'h0000_0200, 32'hDEAD_0000);
        cyc;
        idle;
        checks++; if ({count, mem_addr} !== {3'd4, 32'h100}) begin failures++; $display("FAIL fill_overflow got=cnt%0d/%h exp=4/00000100", count, mem_addr); end
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
                failures++;
                $display("FAIL fill_order%0d got=req%b/%h/%h exp=1/%h/%h", i, mem_req, mem_addr, mem_wdata, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            cyc;
        end
        mem_addr_ok = 1'b0;
        checks++; if ({count, drained} !== 4'b000_0) begin failures++; $display("FAIL fill_empty got=cnt%0d/drn%b exp=0/0", count, drained); end
        cyc;
        mem_data_ok = 1'b0;
        checks++; if (drained !== 1'b1) begin failures++; $display("FAIL fill_drained got=%b exp=1", drained); end
    endtask

    task automatic test_max_out;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(2'b11, 32'h10 + 32'(i), 32'h0000_00C0 + 32'(i));
            cyc;
        end
        idle;
        mem_addr_ok = 1'b1;
        cyc;
        checks++; if ({mem_req, count} !== 4'b1_010) begin failures++; $display("FAIL mo_first got=req%b/cnt%0d exp=1/2", mem_req, count); end
        cyc;
        checks++; if ({mem_req, count} !== 4'b0_001) begin failures++; $display("FAIL mo_limit got=req%b/cnt%0d exp=0/1", mem_req, count); end
        cyc;
        checks++; if ({mem_req, count} !== 4'b0_001) begin failures++; $display("FAIL mo_stall got=req%b/cnt%0d exp=0/1", mem_req, count); end
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cyc;
        mem_data_ok = 1'b0;
        checks++; if ({mem_req, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h12, 4'b0100, 32'hC2C2_C2C2}) begin failures++; $display("FAIL mo_reenable got=req%b/%h/%b/%h exp=1/00000012/0100/c2c2c2c2", mem_req, mem_addr, mem_wstrb, mem_wdata); end
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        cyc;
        mem_addr_ok = 1'b0;
        checks++; if ({count, drained} !== 4'b000_0) begin failures++; $display("FAIL mo_simul got=cnt%0d/drn%b exp=0/0", count, drained); end
        cyc;
        mem_data_ok = 1'b0;
        checks++; if (drained !== 1'b1) begin failures++; $display("FAIL mo_const got=%b exp=1", drained); end
    endtask

    task automatic test_misaligned;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        put(2'b01, 32'h0000_3001, 32'hDEAD_BEEF);
        #1;
`ifdef UNALIGNED_TRAP_EN
        checks++; if ({st_ades, badvaddr} !== {1'b1, 32'h3001}) begin failures++; $display("FAIL mis_ades got=%b/%h exp=1/00003001", st_ades, badvaddr); end
        flush = 1'b1;
        #1;
        checks++; if (st_ades !== 1'b1) begin failures++; $display("FAIL mis_ades_flush got=%b exp=1", st_ades); end
        cyc;
        flush = 1'b0;
        idle;
        #1;
        checks++; if ({count, st_ades, badvaddr} !== 36'h0) begin failures++; $display("FAIL mis_drop got=cnt%0d/%b/%h exp=0/0/0", count, st_ades, badvaddr); end
`else
        checks++; if ({st_ades, badvaddr} !== 33'h0) begin failures++; $display("FAIL mis_ades got=%b/%h exp=0/0", st_ades, badvaddr); end
        cyc;
        idle;
        checks++; if ({count, mem_addr, mem_wstrb, mem_wdata} !== {3'd1, 32'h3000, 4'b1111, 32'hDEAD_BEEF}) begin failures++; $display("FAIL mis_align got=cnt%0d/%h/%b/%h exp=1/00003000/1111/deadbeef", count, mem_addr, mem_wstrb, mem_wdata); end
        put(2'b10, 32'h0000_3003, 32'h0000_1234);
        cyc;
        idle;
        mem_addr_ok = 1'b1;
        cyc;
        mem_addr_ok = 1'b0;
        checks++; if ({mem_addr, mem_wstrb, mem_wdata} !== {32'h3002, 4'b1100, 32'h1234_1234}) begin failures++; $display("FAIL mis_align_sh got=%h/%b/%h exp=00003002/1100/12341234", mem_addr, mem_wstrb, mem_wdata); end
        mem_addr_ok = 1'b1;
        cyc;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cyc;
        cyc;
        mem_data_ok = 1'b0;
        checks++; if (drained !== 1'b1) begin failures++; $display("FAIL mis_drained got=%b exp=1", drained); end
`endif
    endtask

    task automatic test_reset_mid;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(2'b01, 32'h500 + 32'(4 * i), 32'h5 + 32'(i));
            cyc;
        end
        idle;
        mem_addr_ok = 1'b1;
        cyc;
        mem_addr_ok = 1'b0;
        checks++; if ({count, drained} !== 4'b011_0) begin failures++; $display("FAIL rm_pre got=cnt%0d/drn%b exp=3/0", count, drained); end
        #1;
        resetn = 1'b0;
        #1;
        checks++; if ({count, drained, mem_req, st_ready} !== 6'b000_1_0_1) begin failures++; $display("FAIL rm_async got=cnt%0d/drn%b/req%b/rdy%b exp=0/1/0/1", count, drained, mem_req, st_ready); end
        resetn = 1'b1;
        cyc;
        checks++; if ({count, drained, mem_req} !== 5'b000_1_0) begin failures++; $display("FAIL rm_after got=cnt%0d/drn%b/req%b exp=0/1/0", count, drained, mem_req); end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        idle;
        test_reset;
        test_sb;
        test_sh;
        test_ignored;
        test_fill;
        test_max_out;
        test_misaligned;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
